// File: rtl/tl_pkg.sv
// Shared types and parameter legality helper for the phase-timed traffic light controller.
package tl_pkg;

    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_ALLRED = 2'b10
    } tl_state_e;

    function automatic bit params_ok(input int n_phase, input int cnt_w, input int min_green,
                                     input int max_green, input int yellow_cyc);
        return (n_phase >= 2) && (min_green >= 1) && (min_green <= max_green) &&
               (max_green < (1 << cnt_w)) && (yellow_cyc >= 1) && (yellow_cyc < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/tl_cntr_phase_timed_if.sv
// Sensor-in / lamp-out bundle; master is the controller, slave is the sensor/lamp side.
interface tl_cntr_phase_timed_if #(
    parameter int N_PHASE = 4
);
    localparam int PH_W = $clog2(N_PHASE);

    logic [N_PHASE-1:0] T;
    logic [N_PHASE-1:0] green;
    logic [N_PHASE-1:0] yellow;
    logic [N_PHASE-1:0] red;
    logic [PH_W-1:0]    phase;
    logic [1:0]         state;

    modport master (input T, output green, output yellow, output red, output phase, output state);
    modport slave  (output T, input green, input yellow, input red, input phase, input state);
endinterface

// File: rtl/tl_next_phase.sv
// Round-robin search for the first demanding phase after p (p itself excluded).
// Purely combinational; nxt_phase is only meaningful when found is set.
module tl_next_phase #(
    parameter int N_PHASE = 4,
    parameter int PH_W    = $clog2(N_PHASE)
) (
    input  logic [N_PHASE-1:0] t,
    input  logic [PH_W-1:0]    p,
    output logic [PH_W-1:0]    nxt_phase,
    output logic               found
);
    int idx;

    always_comb begin
        nxt_phase = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i < N_PHASE; i++) begin
            // Explicit wrap keeps non-power-of-two phase counts in range.
            idx = int'(p) + i;
            if (idx >= N_PHASE) idx = idx - N_PHASE;
            if (!found && t[idx]) begin
                found     = 1'b1;
                nxt_phase = PH_W'(idx);
            end
        end
    end
endmodule

// File: rtl/tl_cntr_phase_timed.sv
// N-phase traffic light controller with min/max green, fixed yellow and one-cycle all-red.
// Lamps decode registers only; a sensor change at edge k steers the decision at edge k+1.
module tl_cntr_phase_timed
    import tl_pkg::*;
#(
    parameter int N_PHASE    = 4,
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 16,
    parameter int YELLOW_CYC = 3,
    parameter int PH_W       = $clog2(N_PHASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    tl_cntr_phase_timed_if.master bus
);
    if (!params_ok(N_PHASE, CNT_W, MIN_GREEN, MAX_GREEN, YELLOW_CYC)) begin : g_bad_params
        $error("tl_cntr_phase_timed: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(N_PHASE - 1);

    tl_state_e          state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_PHASE-1:0] ph_oh;
    logic               other_dem;
    logic [PH_W-1:0]    srch_phase;
    logic               srch_found;

    tl_next_phase #(.N_PHASE(N_PHASE), .PH_W(PH_W)) u_next_phase (
        .t         (bus.T),
        .p         (phase_q),
        .nxt_phase (srch_phase),
        .found     (srch_found)
    );

    assign ph_oh     = N_PHASE'(1) << phase_q;
    assign other_dem = |(bus.T & ~ph_oh);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_GREEN: begin
                if ((cnt_q >= MIN_LAST) && other_dem && (!bus.T[phase_q] || (cnt_q == MAX_LAST))) begin
                    state_d = S_YELLOW;
                    cnt_d   = '0;
                end else if (cnt_q != MAX_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_YELLOW: begin
                if (cnt_q == YEL_LAST) begin
                    state_d = S_ALLRED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ALLRED: begin
                state_d = S_GREEN;
                cnt_d   = '0;
                if (srch_found)            phase_d = srch_phase;
                else if (phase_q == PH_LAST) phase_d = '0;
                else                       phase_d = phase_q + 1'b1;
            end
            default: begin
                // Unreachable encoding: recover to a known safe phase.
                state_d = S_GREEN;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_GREEN;
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.green  = (state_q == S_GREEN)  ? ph_oh : '0;
    assign bus.yellow = (state_q == S_YELLOW) ? ph_oh : '0;
    assign bus.red    = ~(bus.green | bus.yellow);
    assign bus.phase  = phase_q;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_tl_cntr_phase_timed.sv
// Bench for tl_cntr_phase_timed: directed scenarios plus random demand against a reference model.
module tb_tl_cntr_phase_timed;
    localparam int N  = 4;
    localparam int MN = 4;
    localparam int MX = 16;
    localparam int Y  = 3;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // Reference model: mode 0 = green, 1 = yellow, 2 = all-red; el = cycles already spent in mode.
    int m_mode;
    int m_phase;
    int m_el;

    tl_cntr_phase_timed_if #(.N_PHASE(N)) bus ();

    tl_cntr_phase_timed #(
        .N_PHASE(N), .CNT_W(8), .MIN_GREEN(MN), .MAX_GREEN(MX), .YELLOW_CYC(Y)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_step(input logic [N-1:0] t, input logic rst);
        bit others;
        bit hit;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_el = 0;
            return;
        end
        case (m_mode)
            0: begin
                others = 1'b0;
                for (int q = 0; q < N; q++) if (q != m_phase && t[q]) others = 1'b1;
                // Green has run m_el+1 cycles once this edge passes.
                if ((m_el + 1 >= MN) && others && (!t[m_phase] || (m_el + 1 >= MX))) begin
                    m_mode = 1; m_el = 0;
                end else begin
                    m_el = m_el + 1;
                end
            end
            1: begin
                if (m_el + 1 == Y) begin m_mode = 2; m_el = 0; end
                else m_el = m_el + 1;
            end
            default: begin
                hit = 1'b0;
                for (int k = 1; k < N; k++) begin
                    if (!hit && t[(m_phase + k) % N]) begin
                        hit = 1'b1;
                        m_phase = (m_phase + k) % N;
                    end
                end
                if (!hit) m_phase = (m_phase + 1) % N;
                m_mode = 0; m_el = 0;
            end
        endcase
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [3:0] g, yl, r;
        g  = (m_mode == 0) ? 4'(1 << m_phase) : 4'b0000;
        yl = (m_mode == 1) ? 4'(1 << m_phase) : 4'b0000;
        r  = ~(g | yl);
        return {g, yl, r, 2'(m_phase), 2'(m_mode)};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {bus.green, bus.yellow, bus.red, bus.phase, bus.state};
    endfunction

    task automatic tick(input logic [N-1:0] t, input logic rst);
        bus.T = t;
        reset = rst;
        @(posedge clk);
        model_step(t, rst);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input logic [N-1:0] t, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick(t, 1'b0);
            if (bus.state == s) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick(4'b1111, 1'b1);
        tick(4'b1111, 1'b1);
        vectors++;
        if (obs_vec() !== 16'b0001_0000_1110_00_00) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs_vec(), 16'b0001_0000_1110_00_00);
        end
    endtask

    task automatic test_idle();
        tick(4'b0000, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick(4'b0000, 1'b0);
            vectors++;
            if (bus.green !== 4'b0001 || bus.state !== 2'b00 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL idle cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_skip();
        logic [15:0] seq [9];
        // Green was already showing for the reset cycle, then three more greens.
        seq = '{16'h10e0, 16'h10e0, 16'h10e0, 16'h01e1, 16'h01e1, 16'h01e1,
                16'h00f2, 16'h40b8, 16'h40b8};
        tick(4'b0100, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(4'b0100, 1'b0);
            vectors++;
            if (obs_vec() !== seq[i] || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL skip cyc%0d: got %h want %h", i, obs_vec(), seq[i]);
            end
        end
        for (int i = 0; i < 30; i++) tick(4'b0100, 1'b0);
        vectors++;
        if (bus.green !== 4'b0100 || bus.phase !== 2'd2) begin
            miscompares++;
            $display("FAIL skip_rest: got green=%b phase=%0d want 0100/2", bus.green, bus.phase);
        end
    endtask

    task automatic test_contended();
        int g0, changes;
        logic [3:0] prev;
        tick(4'b0011, 1'b1);
        g0 = 1; changes = 0; prev = bus.green;
        for (int i = 0; i < 100; i++) begin
            tick(4'b0011, 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL contend cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i < 15 && bus.green == 4'b0001) g0++;
        end
        vectors++;
        if (g0 != MX) begin
            miscompares++;
            $display("FAIL contend_len: got %0d want %0d", g0, MX);
        end
    endtask

    task automatic test_drop_in_allred();
        bit hit;
        tick(4'b0010, 1'b1);
        wait_state(2'b10, 4'b0010, hit);
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL drop_wait: got timeout want all-red");
        end
        tick(4'b0000, 1'b0);
        vectors++;
        if (bus.green !== 4'b0010 || bus.phase !== 2'd1 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL drop_default: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        bit hit;
        tick(4'b1000, 1'b1);
        wait_state(2'b10, 4'b1000, hit);
        tick(4'b1000, 1'b0);
        vectors++;
        if (!hit || bus.phase !== 2'd3) begin
            miscompares++;
            $display("FAIL wrap_reach3: got phase=%0d want 3", bus.phase);
        end
        wait_state(2'b10, 4'b0001, hit);
        tick(4'b0001, 1'b0);
        vectors++;
        if (!hit || bus.green !== 4'b0001 || bus.phase !== 2'd0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_in_yellow();
        bit hit;
        tick(4'b0010, 1'b1);
        wait_state(2'b01, 4'b0010, hit);
        tick(4'b0010, 1'b0);
        vectors++;
        if (!hit || bus.state !== 2'b01) begin
            miscompares++;
            $display("FAIL yel_second: got state=%b want 01", bus.state);
        end
        tick(4'b0010, 1'b1);
        vectors++;
        if (obs_vec() !== 16'b0001_0000_1110_00_00) begin
            miscompares++;
            $display("FAIL yel_reset: got %h want %h", obs_vec(), 16'b0001_0000_1110_00_00);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] t;
        logic         r;
        t = 4'b0000;
        tick(t, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) t = 4'($urandom);
            r = ($urandom_range(0, 299) == 0);
            tick(t, r);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        bus.T = '0;
        reset = 1'b1;
        m_mode = 0; m_phase = 0; m_el = 0;
        test_reset();
        test_idle();
        test_skip();
        test_contended();
        test_drop_in_allred();
        test_wrap();
        test_reset_in_yellow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
